// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: tracks in-flight
// instructions in a shadow EX/MEM/WB pipeline and drives stalls, flushes and forwarding.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_op_type,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3, OP_OR = 4'd4,
    OP_SLT = 4'd5, OP_LW  = 4'd6, OP_SW  = 4'd7, OP_BEQ = 4'd8, OP_J   = 4'd9
  } op_e;

  typedef enum logic [2:0] {C_NORMAL, C_BUSY, C_BR, C_LU, C_JMP} cond_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       wr;
    logic       ld;
  } entry_t;

  function automatic logic uses_rs(input logic [3:0] op);
    return op inside {[OP_ADD:OP_BEQ]};
  endfunction

  function automatic logic uses_rt(input logic [3:0] op);
    return op inside {[OP_ADD:OP_SLT], OP_SW, OP_BEQ};
  endfunction

  // MEM wins over WB; a load in MEM has no result yet, so it never forwards from there.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic used,
                                         input entry_t mem, input entry_t wb);
    if (!used)                                          return 2'b00;
    if (mem.valid && mem.wr && !mem.ld && mem.dest == src) return 2'b10;
    if (wb.valid && wb.wr && wb.dest == src)            return 2'b01;
    return 2'b00;
  endfunction

  entry_t ex_s, mem_s, wb_s;
  entry_t id_e;
  cond_e  cond;
  logic   br_hit, lu_hit;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    id_e       = '0;
    id_e.valid = 1'b1;
    id_e.op    = id_op_type;
    id_e.rs    = id_rs;
    id_e.rt    = id_rt;
    id_e.ld    = (id_op_type == OP_LW);
    if (id_op_type inside {[OP_ADD:OP_SLT]}) id_e.dest = id_rd;
    else if (id_op_type == OP_LW)            id_e.dest = id_rt;
    id_e.wr = (id_op_type inside {[OP_ADD:OP_LW]}) && (id_e.dest != 5'd0);
  end

  assign br_hit = ex_s.valid && (ex_s.op == OP_BEQ) && ex_branch_taken;
  assign lu_hit = ex_s.valid && ex_s.ld && ex_s.wr &&
                  ((uses_rs(id_op_type) && ex_s.dest == id_rs) ||
                   (uses_rt(id_op_type) && ex_s.dest == id_rt));

  always_comb begin
    cond = C_NORMAL;
    if      (mem_busy)               cond = C_BUSY;
    else if (br_hit)                 cond = C_BR;
    else if (lu_hit)                 cond = C_LU;
    else if (id_op_type == OP_J)     cond = C_JMP;
  end

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_en      = 1'b0;
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
    if (!rst) begin
      fwd_a = fwd_sel(ex_s.rs, ex_s.valid && uses_rs(ex_s.op), mem_s, wb_s);
      fwd_b = fwd_sel(ex_s.rt, ex_s.valid && uses_rt(ex_s.op), mem_s, wb_s);
      unique case (cond)
        C_BUSY: ;
        C_BR: begin
          pc_en = 1'b1; if_id_en = 1'b1; if_id_flush = 1'b1;
          id_ex_bubble = 1'b1; pipe_en = 1'b1;
        end
        C_LU: begin
          id_ex_bubble = 1'b1; pipe_en = 1'b1;
        end
        C_JMP: begin
          pc_en = 1'b1; if_id_en = 1'b1; if_id_flush = 1'b1; pipe_en = 1'b1;
        end
        default: begin
          pc_en = 1'b1; if_id_en = 1'b1; pipe_en = 1'b1;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all stages shift on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_s      <= '0;
      mem_s     <= '0;
      wb_s      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pipe_en) begin
        wb_s  <= mem_s;
        mem_s <= ex_s;
        ex_s  <= (cond == C_BR || cond == C_LU) ? entry_t'('0) : id_e;
      end
      if ((cond == C_BUSY || cond == C_LU) && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((cond == C_BR || cond == C_JMP) && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a table of per-cycle vectors with hand-computed
// outputs, then hand sequences for asynchronous reset and counter saturation.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       id_op_type;
  logic [4:0]       id_rs, id_rt, id_rd;
  logic             ex_branch_taken, mem_busy;
  logic             pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_total = 0;
  int n_bad   = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_op_type(id_op_type), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_en(pipe_en),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en}
  localparam logic [4:0] NORM = 5'b11001;
  localparam logic [4:0] LU   = 5'b00011;
  localparam logic [4:0] BR   = 5'b11111;
  localparam logic [4:0] JMP  = 5'b11101;
  localparam logic [4:0] HOLD = 5'b00000;

  typedef struct {
    logic [3:0] op;
    logic [4:0] rs, rt, rd;
    logic       tk, busy;
    logic [4:0] ctl;
    logic [1:0] fa, fb;
    int         sc, fc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic tk, input logic busy,
                              input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                              input int sc, input int fc);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.tk = tk; v.busy = busy;
    v.ctl = ctl; v.fa = fa; v.fb = fb; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic tk, input logic busy);
    id_op_type = op; id_rs = rs; id_rt = rt; id_rd = rd;
    ex_branch_taken = tk; mem_busy = busy;
  endtask

  function automatic logic [4:0] ctl_now();
    return {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en};
  endfunction

  initial begin
    // Op codes: 0 nop, 1 add, 2 sub, 6 lw, 7 sw, 8 beq, 9 j, 12 reserved (nop).
    vecs.push_back(mk(1, 1, 2, 3, 0, 0, NORM, 2'b00, 2'b00, 0, 0)); // add r3,r1,r2
    vecs.push_back(mk(2, 3, 5, 4, 0, 0, NORM, 2'b00, 2'b00, 0, 0)); // sub r4,r3,r5
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, NORM, 2'b10, 2'b00, 0, 0)); // sub in EX: from MEM
    vecs.push_back(mk(1, 1, 2, 7, 0, 0, NORM, 2'b00, 2'b00, 0, 0)); // add r7,r1,r2
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, NORM, 2'b00, 2'b00, 0, 0)); // nop
    vecs.push_back(mk(2, 7, 9, 8, 0, 0, NORM, 2'b00, 2'b00, 0, 0)); // sub r8,r7,r9
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, NORM, 2'b01, 2'b00, 0, 0)); // sub in EX: from WB
    vecs.push_back(mk(6, 1, 2, 0, 0, 0, NORM, 2'b00, 2'b00, 0, 0)); // lw r2
    vecs.push_back(mk(1, 2, 2, 4, 0, 0, LU,   2'b00, 2'b00, 1, 0)); // add r4,r2,r2 stalls
    vecs.push_back(mk(1, 2, 2, 4, 0, 0, NORM, 2'b00, 2'b00, 1, 0)); // re-presented
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, NORM, 2'b01, 2'b01, 1, 0)); // add in EX, lw in WB
    vecs.push_back(mk(6, 1, 5, 0, 0, 0, NORM, 2'b00, 2'b00, 1, 0)); // lw r5
    vecs.push_back(mk(7, 1, 5, 0, 0, 0, LU,   2'b00, 2'b00, 2, 0)); // sw r5 stalls
    vecs.push_back(mk(7, 1, 5, 0, 0, 0, NORM, 2'b00, 2'b00, 2, 0)); // re-presented
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, NORM, 2'b00, 2'b01, 2, 0)); // sw data from WB
    vecs.push_back(mk(6, 1, 0, 0, 0, 0, NORM, 2'b00, 2'b00, 2, 0)); // lw r0
    vecs.push_back(mk(1, 0, 0, 4, 0, 0, NORM, 2'b00, 2'b00, 2, 0)); // add r4,r0,r0 no stall
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, NORM, 2'b00, 2'b00, 2, 0)); // r0 never forwards
    vecs.push_back(mk(8, 1, 2, 0, 0, 0, NORM, 2'b00, 2'b00, 2, 0)); // beq
    vecs.push_back(mk(1, 6, 6, 4, 1, 0, BR,   2'b00, 2'b00, 2, 1)); // taken, consumer flushed
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, NORM, 2'b00, 2'b00, 2, 1)); // taken ignored, EX empty
    vecs.push_back(mk(8, 1, 2, 0, 0, 0, NORM, 2'b00, 2'b00, 2, 1)); // beq
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, NORM, 2'b00, 2'b00, 2, 1)); // not taken
    vecs.push_back(mk(9, 0, 0, 0, 0, 0, JMP,  2'b00, 2'b00, 2, 2)); // j
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, NORM, 2'b00, 2'b00, 2, 2)); // j in EX
    vecs.push_back(mk(8, 1, 2, 0, 0, 0, NORM, 2'b00, 2'b00, 2, 2)); // beq
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, HOLD, 2'b00, 2'b00, 3, 2)); // busy x3 over taken beq
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, HOLD, 2'b00, 2'b00, 4, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, HOLD, 2'b00, 2'b00, 5, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, BR,   2'b00, 2'b00, 5, 3)); // branch flush after busy
    vecs.push_back(mk(12, 3, 3, 3, 0, 0, NORM, 2'b00, 2'b00, 5, 3)); // reserved op = nop

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #3;
    check("reset_ctl", 32'(ctl_now()), 32'(HOLD));
    check("reset_fwd", 32'({fwd_a, fwd_b}), 32'h0);
    check("reset_cnt", 32'({stall_cnt, flush_cnt}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].tk, vecs[i].busy);
      #1;
      check($sformatf("v%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      check($sformatf("v%0d_fwd_a", i), 32'(fwd_a), 32'(vecs[i].fa));
      check($sformatf("v%0d_fwd_b", i), 32'(fwd_b), 32'(vecs[i].fb));
      @(posedge clk); #1;
      check($sformatf("v%0d_stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].sc));
      check($sformatf("v%0d_flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].fc));
    end

    // Asynchronous reset between edges while a forward is active.
    drive(1, 1, 2, 3, 0, 0);
    @(posedge clk); #1;
    drive(2, 3, 5, 4, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("pre_rst_fwd_a", 32'(fwd_a), 32'(2'b10));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ctl", 32'(ctl_now()), 32'(HOLD));
    check("async_rst_fwd_a", 32'(fwd_a), 32'h0);
    check("async_rst_stall_cnt", 32'(stall_cnt), 32'h0);
    check("async_rst_flush_cnt", 32'(flush_cnt), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_ctl", 32'(ctl_now()), 32'(NORM));
    check("post_rst_fwd", 32'({fwd_a, fwd_b}), 32'h0);

    // Saturation: 20 busy cycles on a 4-bit counter.
    drive(0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      check($sformatf("sat_stall_cnt_%0d", k), 32'(stall_cnt), 32'((k > 15) ? 15 : k));
    end
    check("sat_flush_cnt", 32'(flush_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It consumes the 4-bit `op_type` codes and register fields decoded in ID and tracks every in-flight instruction in a shadow pipeline (EX, MEM, WB). From that state it generates PC/IF-ID enables, flushes, bubbles and operand-forwarding selects. It also keeps saturating stall and flush counters for performance debug.

## Interface
- `CNT_W`, default 16: width of the performance counters.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `id_op_type` input 4: ID-stage op code (0 nop, 1 add, 2 sub, 3 and, 4 or, 5 slt, 6 lw, 7 sw, 8 beq, 9 j, 10–15 treated as nop).
- `id_rs`, `id_rt`, `id_rd` input 5 each: ID-stage register fields.
- `ex_branch_taken` input 1: beq comparison result from EX; ignored unless the EX shadow holds a valid beq.
- `mem_busy` input 1: data memory wait request; freezes the whole pipeline.
- `pc_en` output 1: PC load enable.
- `if_id_en` output 1: IF/ID register enable.
- `if_id_flush` output 1: clears IF/ID to nop on the next edge.
- `id_ex_bubble` output 1: loads nop into ID/EX on the next edge.
- `pipe_en` output 1: enable for ID/EX, EX/MEM and MEM/WB.
- `fwd_a`, `fwd_b` output 2: EX operand source. 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.
- `stall_cnt`, `flush_cnt` output CNT_W: saturating event counters.

## Operation
- Shadow entry per stage: valid, op_type, rs, rt, dest, wr (register writer), ld (load).
- Dest is rd for op 1–5, rt for op 6. Writers are op 1–6 only. Dest 0 clears wr.
- Operand use:
  - rs is used by op 1–8.
  - rt is used by op 1–5, 7 and 8.
- Conditions, evaluated in priority order:
  1. BUSY: `mem_busy` = 1.
  2. BR: EX is a valid beq and `ex_branch_taken` = 1.
  3. LU (load-use): EX has ld & wr, and its dest matches a used ID source.
  4. JMP: `id_op_type` = 9.
- Outputs per condition (all others are NORMAL):
  - BUSY: `pc_en`=0, `if_id_en`=0, `pipe_en`=0, flush=0, bubble=0. The shadow pipeline holds.
  - BR: `pc_en`=1, `if_id_en`=1, `if_id_flush`=1, `id_ex_bubble`=1, `pipe_en`=1. The shadow EX entry becomes invalid.
  - LU: `pc_en`=0, `if_id_en`=0, `id_ex_bubble`=1, `pipe_en`=1. The shadow EX entry becomes invalid and ID is re-presented next cycle.
  - JMP: `pc_en`=1, `if_id_en`=1, `if_id_flush`=1, `pipe_en`=1. The j itself advances to EX as a non-writer.
  - NORMAL: `pc_en`=1, `if_id_en`=1, `pipe_en`=1, flush=0, bubble=0.
- Shadow advance whenever `pipe_en`=1: WB<=MEM, MEM<=EX, and EX<=decoded ID (or invalid under BR/LU).
- Forwarding for the EX operand rs (rt is identical, producing `fwd_b`):
  - 10 if MEM is valid, wr, not ld, and MEM.dest == EX.rs.
  - Otherwise 01 if WB is valid, wr, and WB.dest == EX.rs.
  - Otherwise 00.
  - MEM has priority over WB. Forwarding is 00 when EX is invalid or does not use the operand.
- Counters (saturate at 2^CNT_W−1, no wrap):
  - `stall_cnt` +1 every cycle with BUSY or LU.
  - `flush_cnt` +1 every cycle with BR or JMP.
- Simultaneous events:
  - BR together with LU: BR wins; the flushed ID instruction cannot cause a stall.
  - BUSY together with BR: hold; the branch re-evaluates after `mem_busy` falls, with EX unchanged.

## Timing
- All control outputs are combinational from the registered shadow state plus current ID inputs, effective at the next rising edge.
- Shadow state and counters update only on `clk` rising edges.
- Load-use stall lasts exactly 1 cycle. The lw then sits in MEM with a bubble in EX, so its result forwards via 01.
- Taken beq costs 2 slots (IF/ID and ID/EX flushed). A j costs 1 slot.
- Reset behaviour while `rst`=1 (asynchronous):
  - All shadow entries are invalid and both counters are 0.
  - Outputs are forced to `pc_en`=0, `if_id_en`=0, `pipe_en`=0, flush=0, bubble=0, `fwd_a`=`fwd_b`=00.
- First cycle after reset release: NORMAL outputs with an empty shadow.
- Reset mid-operation discards all in-flight tracking; there is no partial state retention.

## Test plan
- **Back-to-back forwarding.** Stimulus: add r3,r1,r2 then sub r4,r3,r5.
  - Required: when sub is in EX, `fwd_a`=10, with no stall.
  - With one nop inserted between them: `fwd_a`=01.
- **Load-use.** Stimulus: lw r2 then add r4,r2,r2.
  - Required: exactly one cycle with `pc_en`=0, `id_ex_bubble`=1, `stall_cnt`=1.
  - Then `fwd_a`=`fwd_b`=01 when add reaches EX.
  - Variant with sw r2 as the consumer: also stalls.
- **Register 0 never hazards.** Stimulus: lw r0 followed by add r4,r0,r0.
  - Required: no stall, and forwarding stays 00.
- **Taken branch.** Stimulus: beq in EX with `ex_branch_taken`=1 while ID holds a load-use consumer.
  - Required: `if_id_flush`=1, `id_ex_bubble`=1, `pc_en`=1, `flush_cnt`+1, and no stall.
  - Stimulus: the same beq with `ex_branch_taken`=0.
  - Required: NORMAL outputs.
- **Memory busy.** Stimulus: `mem_busy` high for 3 cycles during a taken-branch cycle.
  - Required: all enables 0 for 3 cycles and `stall_cnt`+3.
  - Then the branch flush occurs on the 4th cycle.
- **Reset and saturation.**
  - Stimulus: assert `rst` mid-stream, asynchronously between edges.
  - Required: outputs go to reset values immediately and the counters read 0.
  - Stimulus: run with `CNT_W`=4 under 20 stall cycles.
  - Required: `stall_cnt` saturates at 15.
